alu_mod_sequencer: RTL and testbench
====================================

// Module: alu_mod_sequencer
// PURPOSE
//  Multi-cycle initiator for the 32-bit ALU port set (alu_src1/alu_src2/alu_ctr in, alu_result/zero_bit out).
//  Computes A mod B and A div B by driving the shared ALU with AND, LESS THAN and SUB steps and sampling results.
//  Sits between the control path and the ALU: valid/ready request in, valid/ready result out.
// PARAMETERS
//  MAX_ITER  1024  max SUB steps per request; exceeding it ends the request with a timeout error
// PORTS
//  clk           in   1   system clock, all state on rising edge
//  reset         in   1   asynchronous, active-low reset (reset==0 clears all state immediately)
//  start_valid   in   1   request present
//  start_ready   out  1   sequencer can accept a request (high only in IDLE)
//  op_a          in   32  dividend, sampled on accept
//  op_b          in   32  divisor, sampled on accept
//  result_valid  out  1   result present (high only in DONE)
//  result_ready  in   1   consumer takes result
//  remainder     out  32  A mod B
//  quotient      out  32  A div B (zero-extended SUB count)
//  err           out  2   00 ok, 01 divide-by-zero, 10 operand out of range, 11 timeout
//  alu_src1      out  32  to ALU
//  alu_src2      out  32  to ALU
//  alu_ctr       out  3   to ALU: 000 AND, 100 LESS THAN, 110 SUB
//  alu_result    in   32  from ALU (combinational, same cycle)
//  zero_bit      in   1   from ALU (alu_result==0)
// BEHAVIOUR
//  Reset: state=IDLE, R/B/remainder/quotient/iter=0, err=00; alu_src1/src2=0, alu_ctr=000.
//  Accept = start_valid && start_ready at a rising edge; latch R<=op_a, B<=op_b, iter<=0, err<=00.
//  Range rule: if op_a[31] or op_b[31] at accept -> DONE next, err=10, remainder=0, quotient=0.
//  States (alu outputs are decoded from registered state only, no input-to-output paths):
//   IDLE: src=0/0, ctr=000. Accept -> CHKZ (or DONE on range error).
//   CHKZ: src1=B, src2=B, ctr=000. zero_bit=1 -> DONE, err=01, remainder=0, quotient=0; else -> CMP.
//   CMP:  src1=R, src2=B, ctr=100. alu_result[0]=1 (R<B) -> DONE, remainder=R, quotient=iter.
//         else if iter==MAX_ITER -> DONE, err=11, remainder=R, quotient=iter; else -> SUB.
//   SUB:  src1=R, src2=B, ctr=110. R<=alu_result, iter<=iter+1 -> CMP.
//   DONE: outputs held stable; result_ready=1 -> IDLE.
//  Latency (accept edge to result_valid): range err 1 cycle; div0 2; normal 3+2*q (q=quotient).
//  Timeout: q>MAX_ITER -> err=11 after 3+2*MAX_ITER cycles; iter width $clog2(MAX_ITER+1).
//  Operands below 2^31 make ALU LESS THAN signedness irrelevant; SUB never underflows (R>=B).
//  remainder/quotient/err change only on entry to DONE and hold until the next DONE entry.
//  start_ready=0 in DONE: a start_valid during result handshake waits one cycle, accepted in IDLE.
//  start_valid deassertion while not ready is legal; no request is lost or duplicated.
//  Reset mid-operation: abort to IDLE, result_valid=0, no partial result is reported.
// TESTING
//  A=17,B=5 -> result_valid 9 cycles after accept, remainder=2, quotient=3, err=00.
//  A=3,B=7 -> 3 cycles, remainder=3, quotient=0, err=00; alu_ctr sequence 000,100 seen.
//  A=42,B=0 -> 2 cycles, err=01, remainder=0, quotient=0; zero_bit path exercised.
//  A=32'h8000_0000,B=3 -> 1 cycle, err=10; MAX_ITER=4,A=100,B=1 -> err=11, quotient=4, remainder=96.
//  Hold result_ready=0 10 cycles in DONE -> outputs stable, start_ready=0; then back-to-back requests.
//  Drop reset to 0 during SUB of A=1000,B=3 -> IDLE immediately, result_valid=0; next request correct.

Source files
------------

// File: rtl/alu_mod_sequencer.sv
// Multi-cycle A mod B / A div B sequencer that borrows a shared 32-bit ALU,
// stepping it through AND (zero test), LESS THAN (compare) and SUB (subtract).
module alu_mod_sequencer #(
    parameter int MAX_ITER = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [31:0] remainder,
    output logic [31:0] quotient,
    output logic [1:0]  err,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    output logic [2:0]  alu_ctr,
    input  logic [31:0] alu_result,
    input  logic        zero_bit
);

    localparam int IW = $clog2(MAX_ITER + 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] CHKZ = 3'd1;
    localparam logic [2:0] CMP  = 3'd2;
    localparam logic [2:0] SUB  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam logic [2:0] CTR_AND = 3'b000;
    localparam logic [2:0] CTR_LT  = 3'b100;
    localparam logic [2:0] CTR_SUB = 3'b110;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_DIV0  = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;

    logic [2:0]    state;
    logic [31:0]   r_reg;
    logic [31:0]   b_reg;
    logic [IW-1:0] iter;

    assign start_ready  = (state == IDLE);
    assign result_valid = (state == DONE);

    // ALU controls depend only on registered state, so no input reaches them combinationally.
    always_comb begin
        alu_src1 = 32'd0;
        alu_src2 = 32'd0;
        alu_ctr  = CTR_AND;
        case (state)
            CHKZ: begin
                alu_src1 = b_reg;
                alu_src2 = b_reg;
                alu_ctr  = CTR_AND;
            end
            CMP: begin
                alu_src1 = r_reg;
                alu_src2 = b_reg;
                alu_ctr  = CTR_LT;
            end
            SUB: begin
                alu_src1 = r_reg;
                alu_src2 = b_reg;
                alu_ctr  = CTR_SUB;
            end
            default: ;
        endcase
    end

    // Result registers are written only on the transition into DONE and hold until the next one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            r_reg     <= 32'd0;
            b_reg     <= 32'd0;
            iter      <= '0;
            remainder <= 32'd0;
            quotient  <= 32'd0;
            err       <= ERR_OK;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        r_reg <= op_a;
                        b_reg <= op_b;
                        iter  <= '0;
                        if (op_a[31] || op_b[31]) begin
                            state     <= DONE;
                            err       <= ERR_RANGE;
                            remainder <= 32'd0;
                            quotient  <= 32'd0;
                        end else begin
                            state <= CHKZ;
                        end
                    end
                end
                CHKZ: begin
                    if (zero_bit) begin
                        state     <= DONE;
                        err       <= ERR_DIV0;
                        remainder <= 32'd0;
                        quotient  <= 32'd0;
                    end else begin
                        state <= CMP;
                    end
                end
                CMP: begin
                    if (alu_result[0]) begin
                        state     <= DONE;
                        err       <= ERR_OK;
                        remainder <= r_reg;
                        quotient  <= 32'(iter);
                    end else if (iter == IW'(MAX_ITER)) begin
                        state     <= DONE;
                        err       <= ERR_TMO;
                        remainder <= r_reg;
                        quotient  <= 32'(iter);
                    end else begin
                        state <= SUB;
                    end
                end
                SUB: begin
                    r_reg <= alu_result;
                    iter  <= iter + 1'b1;
                    state <= CMP;
                end
                DONE: begin
                    if (result_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mod_sequencer.sv
// Directed bench for alu_mod_sequencer: two instances (default and MAX_ITER=4)
// each paired with a behavioural ALU, checked against hand-computed results.
module tb_alu_mod_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sv = 1'b0;
    logic        rr = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;

    int checks = 0;
    int fails = 0;
    int ctr_n = 0;
    logic [2:0] ctr_log [0:15];

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        case (c)
            3'b000:  return a & b;
            3'b100:  return {31'd0, ($signed(a) < $signed(b))};
            3'b110:  return a - b;
            default: return 32'd0;
        endcase
    endfunction

    logic        sr_m, rv_m, sr_t, rv_t;
    logic [31:0] rem_m, quo_m, s1_m, s2_m, res_m, rem_t, quo_t, s1_t, s2_t, res_t;
    logic [1:0]  err_m, err_t;
    logic [2:0]  ctr_m, ctr_t;
    logic        zero_m, zero_t;

    assign res_m  = alu_model(s1_m, s2_m, ctr_m);
    assign zero_m = (res_m == 32'd0);
    assign res_t  = alu_model(s1_t, s2_t, ctr_t);
    assign zero_t = (res_t == 32'd0);

    alu_mod_sequencer dut (
        .clk(clk), .reset(reset), .start_valid(sv & ~sel), .start_ready(sr_m),
        .op_a(op_a), .op_b(op_b), .result_valid(rv_m), .result_ready(rr),
        .remainder(rem_m), .quotient(quo_m), .err(err_m),
        .alu_src1(s1_m), .alu_src2(s2_m), .alu_ctr(ctr_m),
        .alu_result(res_m), .zero_bit(zero_m)
    );

    alu_mod_sequencer #(.MAX_ITER(4)) dut_t (
        .clk(clk), .reset(reset), .start_valid(sv & sel), .start_ready(sr_t),
        .op_a(op_a), .op_b(op_b), .result_valid(rv_t), .result_ready(rr),
        .remainder(rem_t), .quotient(quo_t), .err(err_t),
        .alu_src1(s1_t), .alu_src2(s2_t), .alu_ctr(ctr_t),
        .alu_result(res_t), .zero_bit(zero_t)
    );

    logic        o_sr, o_rv;
    logic [31:0] o_rem, o_quo, o_s1;
    logic [1:0]  o_err;
    logic [2:0]  o_ctr;

    always_comb begin
        o_sr  = sel ? sr_t  : sr_m;
        o_rv  = sel ? rv_t  : rv_m;
        o_rem = sel ? rem_t : rem_m;
        o_quo = sel ? quo_t : quo_m;
        o_err = sel ? err_t : err_m;
        o_ctr = sel ? ctr_t : ctr_m;
        o_s1  = sel ? s1_t  : s1_m;
    end

    // Called just after a falling edge; returns the accept-to-result_valid cycle count.
    task automatic do_request(input logic [31:0] a, input logic [31:0] b, output int cycles);
        int n;
        op_a = a;
        op_b = b;
        sv = 1'b1;
        n = 0;
        while (o_sr !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        sv = 1'b0;
        rr = 1'b0;
        cycles = 1;
        ctr_n = 0;
        while (o_rv !== 1'b1 && cycles < 5000) begin
            if (ctr_n < 16) begin
                ctr_log[ctr_n] = o_ctr;
                ctr_n++;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic consume();
        rr = 1'b1;
        @(negedge clk);
        rr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (rv_m !== 1'b0) begin fails++; $display("[TB] FAIL reset_rv: got %0h expected 0", rv_m); end
        checks++; if (sr_m !== 1'b1) begin fails++; $display("[TB] FAIL reset_sr: got %0h expected 1", sr_m); end
        checks++; if (rem_m !== 32'd0 || quo_m !== 32'd0) begin fails++; $display("[TB] FAIL reset_res: got rem %0h quo %0h expected 0 0", rem_m, quo_m); end
        checks++; if (err_m !== 2'b00) begin fails++; $display("[TB] FAIL reset_err: got %0h expected 0", err_m); end
        checks++; if (ctr_m !== 3'b000 || s1_m !== 32'd0 || s2_m !== 32'd0) begin fails++; $display("[TB] FAIL reset_alu: got ctr %0h src1 %0h src2 %0h expected 0 0 0", ctr_m, s1_m, s2_m); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_normal();
        int lat;
        sel = 1'b0;
        do_request(32'd17, 32'd5, lat);
        checks++; if (lat != 9) begin fails++; $display("[TB] FAIL normal_latency: got %0d expected 9", lat); end
        checks++; if (o_rem !== 32'd2) begin fails++; $display("[TB] FAIL normal_rem: got %0d expected 2", o_rem); end
        checks++; if (o_quo !== 32'd3) begin fails++; $display("[TB] FAIL normal_quo: got %0d expected 3", o_quo); end
        checks++; if (o_err !== 2'b00) begin fails++; $display("[TB] FAIL normal_err: got %0h expected 0", o_err); end
        checks++; if (ctr_log[0] !== 3'b000 || ctr_log[1] !== 3'b100 || ctr_log[2] !== 3'b110) begin
            fails++; $display("[TB] FAIL normal_ctr_seq: got %0h %0h %0h expected 0 4 6", ctr_log[0], ctr_log[1], ctr_log[2]);
        end
        consume();
    endtask

    task automatic test_small();
        int lat;
        do_request(32'd3, 32'd7, lat);
        checks++; if (lat != 3) begin fails++; $display("[TB] FAIL small_latency: got %0d expected 3", lat); end
        checks++; if (o_rem !== 32'd3 || o_quo !== 32'd0 || o_err !== 2'b00) begin
            fails++; $display("[TB] FAIL small_result: got rem %0d quo %0d err %0h expected 3 0 0", o_rem, o_quo, o_err);
        end
        checks++; if (ctr_n != 2 || ctr_log[0] !== 3'b000 || ctr_log[1] !== 3'b100) begin
            fails++; $display("[TB] FAIL small_ctr_seq: got n %0d %0h %0h expected 2 0 4", ctr_n, ctr_log[0], ctr_log[1]);
        end
        consume();
    endtask

    task automatic test_div0();
        int lat;
        do_request(32'd42, 32'd0, lat);
        checks++; if (lat != 2) begin fails++; $display("[TB] FAIL div0_latency: got %0d expected 2", lat); end
        checks++; if (o_err !== 2'b01 || o_rem !== 32'd0 || o_quo !== 32'd0) begin
            fails++; $display("[TB] FAIL div0_result: got err %0h rem %0d quo %0d expected 1 0 0", o_err, o_rem, o_quo);
        end
        consume();
    endtask

    task automatic test_range();
        int lat;
        do_request(32'h8000_0000, 32'd3, lat);
        checks++; if (lat != 1) begin fails++; $display("[TB] FAIL range_latency: got %0d expected 1", lat); end
        checks++; if (o_err !== 2'b10 || o_rem !== 32'd0 || o_quo !== 32'd0) begin
            fails++; $display("[TB] FAIL range_result: got err %0h rem %0d quo %0d expected 2 0 0", o_err, o_rem, o_quo);
        end
        consume();
        do_request(32'd9, 32'h8000_0001, lat);
        checks++; if (lat != 1 || o_err !== 2'b10) begin fails++; $display("[TB] FAIL range_b: got lat %0d err %0h expected 1 2", lat, o_err); end
        consume();
    endtask

    task automatic test_timeout();
        int lat;
        sel = 1'b1;
        do_request(32'd100, 32'd1, lat);
        checks++; if (lat != 11) begin fails++; $display("[TB] FAIL timeout_latency: got %0d expected 11", lat); end
        checks++; if (o_err !== 2'b11 || o_quo !== 32'd4 || o_rem !== 32'd96) begin
            fails++; $display("[TB] FAIL timeout_result: got err %0h quo %0d rem %0d expected 3 4 96", o_err, o_quo, o_rem);
        end
        consume();
        do_request(32'd4, 32'd1, lat);
        checks++; if (lat != 11 || o_err !== 2'b00 || o_quo !== 32'd4 || o_rem !== 32'd0) begin
            fails++; $display("[TB] FAIL timeout_edge: got lat %0d err %0h quo %0d rem %0d expected 11 0 4 0", lat, o_err, o_quo, o_rem);
        end
        consume();
        sel = 1'b0;
    endtask

    task automatic test_hold();
        int lat;
        int bad;
        do_request(32'd23, 32'd4, lat);
        checks++; if (o_rem !== 32'd3 || o_quo !== 32'd5 || lat != 13) begin
            fails++; $display("[TB] FAIL hold_result: got rem %0d quo %0d lat %0d expected 3 5 13", o_rem, o_quo, lat);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o_rv !== 1'b1 || o_sr !== 1'b0 || o_rem !== 32'd3 || o_quo !== 32'd5 || o_err !== 2'b00) bad++;
        end
        checks++; if (bad != 0) begin fails++; $display("[TB] FAIL hold_stable: got %0d unstable cycles expected 0", bad); end
    endtask

    task automatic test_back_to_back();
        int lat;
        rr = 1'b1;
        do_request(32'd20, 32'd6, lat);
        checks++; if (lat != 9 || o_rem !== 32'd2 || o_quo !== 32'd3) begin
            fails++; $display("[TB] FAIL b2b_first: got lat %0d rem %0d quo %0d expected 9 2 3", lat, o_rem, o_quo);
        end
        consume();
        do_request(32'd9, 32'd9, lat);
        checks++; if (lat != 5 || o_rem !== 32'd0 || o_quo !== 32'd1) begin
            fails++; $display("[TB] FAIL b2b_second: got lat %0d rem %0d quo %0d expected 5 0 1", lat, o_rem, o_quo);
        end
        consume();
        repeat (3) @(negedge clk);
        checks++; if (o_rv !== 1'b0 || o_sr !== 1'b1) begin
            fails++; $display("[TB] FAIL b2b_no_dup: got rv %0h sr %0h expected 0 1", o_rv, o_sr);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int n;
        op_a = 32'd1000;
        op_b = 32'd3;
        sv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sv = 1'b0;
        n = 0;
        while (o_ctr !== 3'b110 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (o_ctr !== 3'b110) begin fails++; $display("[TB] FAIL midrst_reach_sub: got ctr %0h expected 6", o_ctr); end
        reset = 1'b0;
        #1;
        checks++; if (o_rv !== 1'b0 || o_sr !== 1'b1 || o_ctr !== 3'b000 || o_s1 !== 32'd0) begin
            fails++; $display("[TB] FAIL midrst_idle: got rv %0h sr %0h ctr %0h src1 %0h expected 0 1 0 0", o_rv, o_sr, o_ctr, o_s1);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_request(32'd10, 32'd3, lat);
        checks++; if (lat != 9 || o_rem !== 32'd1 || o_quo !== 32'd3 || o_err !== 2'b00) begin
            fails++; $display("[TB] FAIL midrst_next: got lat %0d rem %0d quo %0d err %0h expected 9 1 3 0", lat, o_rem, o_quo, o_err);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_small();
        test_div0();
        test_range();
        test_timeout();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
